// File: rtl/irig_b_encoder.sv
// irig_b_encoder: IRIG-B (DC level shift) time-code transmitter, one 100-bit frame per second.
// Ports: sys_clk/sys_rst_n (async active-low) clock and reset; enable starts/stops transmission;
// load strobes second_in/minute_in/hour_in/day_in/year_in into a shadow applied at the next frame;
// irig_b is the registered line, frame_start pulses on the first cycle of bit 0, bit_idx is the bit
// on the line, load_err pulses for a rejected load, pending flags a shadow waiting for a frame.
module irig_b_encoder #(
  parameter int BIT_CYCLES = 1000000,
  parameter int ZERO_HIGH  = 200000,
  parameter int ONE_HIGH   = 500000,
  parameter int P_HIGH     = 800000
) (
  input  logic       sys_clk,
  input  logic       sys_rst_n,
  input  logic       enable,
  input  logic       load,
  input  logic [6:0] second_in,
  input  logic [6:0] minute_in,
  input  logic [5:0] hour_in,
  input  logic [9:0] day_in,
  input  logic [7:0] year_in,
  output logic       irig_b,
  output logic       frame_start,
  output logic [6:0] bit_idx,
  output logic       load_err,
  output logic       pending
);
  localparam int CW = $clog2(BIT_CYCLES);
  localparam logic [CW-1:0] CMAX = CW'(BIT_CYCLES - 1);
  localparam logic [CW-1:0] ZH = CW'(ZERO_HIGH);
  localparam logic [CW-1:0] OH = CW'(ONE_HIGH);
  localparam logic [CW-1:0] PH = CW'(P_HIGH);
  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] SEND = 1'b1;

  logic [0:0]    state;
  logic [CW-1:0] cnt, nxt_cnt, hi;
  logic [6:0]    nxt_bit;
  logic          fs_next, load_ok, started;
  logic [37:0]   sh, act, inc;
  logic [6:0]    a_sec, a_min;
  logic [5:0]    a_hr;
  logic [9:0]    a_day;
  logic [7:0]    a_yr;
  logic          s_w, m_w, h_w, d_w;
  logic [99:0]   one_v, p_v;

  assign {a_sec, a_min, a_hr, a_day, a_yr} = act;

  // A day-366 load is only legal in a leap year, otherwise the carry chain could never reach it.
  assign load_ok = second_in <= 7'd59 && minute_in <= 7'd59 && hour_in <= 6'd23 &&
                   day_in != 10'd0 && day_in <= (year_in[1:0] == 2'd0 ? 10'd366 : 10'd365) &&
                   year_in <= 8'd99;

  assign s_w = a_sec == 7'd59;
  assign m_w = s_w && a_min == 7'd59;
  assign h_w = m_w && a_hr == 6'd23;
  assign d_w = h_w && a_day >= (a_yr[1:0] == 2'd0 ? 10'd366 : 10'd365);
  assign inc = {s_w ? 7'd0 : a_sec + 7'd1,
                m_w ? 7'd0 : s_w ? a_min + 7'd1 : a_min,
                h_w ? 6'd0 : m_w ? a_hr + 6'd1 : a_hr,
                d_w ? 10'd1 : h_w ? a_day + 10'd1 : a_day,
                d_w ? (a_yr == 8'd99 ? 8'd0 : a_yr + 8'd1) : a_yr};

  always_comb begin
    one_v = '0;
    one_v[4:1]   = 4'(a_sec % 7'd10);
    one_v[8:6]   = 3'(a_sec / 7'd10);
    one_v[13:10] = 4'(a_min % 7'd10);
    one_v[17:15] = 3'(a_min / 7'd10);
    one_v[23:20] = 4'(a_hr % 6'd10);
    one_v[26:25] = 2'(a_hr / 6'd10);
    one_v[33:30] = 4'(a_day % 10'd10);
    one_v[38:35] = 4'((a_day / 10'd10) % 10'd10);
    one_v[41:40] = 2'(a_day / 10'd100);
    one_v[53:50] = 4'(a_yr % 8'd10);
    one_v[58:55] = 4'(a_yr / 8'd10);
    for (int i = 0; i < 100; i++) p_v[i] = (i == 0) || (i % 10 == 9);
  end

  // Next line position; the line register is driven from it so irig_b lines up with bit_idx.
  always_comb begin
    nxt_cnt = (state == IDLE || cnt == CMAX) ? '0 : cnt + 1'b1;
    nxt_bit = state == IDLE ? 7'd0 : cnt != CMAX ? bit_idx : bit_idx == 7'd99 ? 7'd0 : bit_idx + 7'd1;
    fs_next = enable && nxt_cnt == '0 && nxt_bit == 7'd0;
    hi = p_v[nxt_bit] ? PH : one_v[nxt_bit] ? OH : ZH;
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state       <= IDLE;
      cnt         <= '0;
      bit_idx     <= 7'd0;
      irig_b      <= 1'b0;
      frame_start <= 1'b0;
      load_err    <= 1'b0;
      pending     <= 1'b0;
      started     <= 1'b0;
      sh          <= '0;
      act         <= '0;
    end else begin
      load_err    <= load && !load_ok;
      frame_start <= fs_next;
      pending     <= (load && load_ok) || (pending && !fs_next);
      if (load && load_ok) sh <= {second_in, minute_in, hour_in, day_in, year_in};
      state       <= enable ? SEND : IDLE;
      cnt         <= enable ? nxt_cnt : '0;
      bit_idx     <= enable ? nxt_bit : 7'd0;
      irig_b      <= enable && nxt_cnt < hi;
      // The very first frame after reset shows the held time as-is; later frames advance by 1 s.
      if (fs_next) begin
        started <= 1'b1;
        act     <= pending ? sh : started ? inc : act;
      end
    end
  end
endmodule

// File: tb/tb_irig_b_encoder.sv
// tb_irig_b_encoder: directed bench for irig_b_encoder with shortened bit timing.
module tb_irig_b_encoder;
  logic       sys_clk = 1'b0;
  logic       sys_rst_n = 1'b0;
  logic       enable = 1'b0;
  logic       load = 1'b0;
  logic [6:0] second_in = '0;
  logic [6:0] minute_in = '0;
  logic [5:0] hour_in = '0;
  logic [9:0] day_in = '0;
  logic [7:0] year_in = '0;
  logic       irig_b, frame_start, load_err, pending;
  logic [6:0] bit_idx;

  int vectors = 0;
  int miscompares = 0;
  int w[100];
  logic [99:0] dv;
  logic [38:0] got;

  irig_b_encoder #(.BIT_CYCLES(100), .ZERO_HIGH(20), .ONE_HIGH(50), .P_HIGH(80)) dut (
    .sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .enable(enable), .load(load),
    .second_in(second_in), .minute_in(minute_in), .hour_in(hour_in), .day_in(day_in),
    .year_in(year_in), .irig_b(irig_b), .frame_start(frame_start), .bit_idx(bit_idx),
    .load_err(load_err), .pending(pending)
  );

  always #5 sys_clk = ~sys_clk;

  function automatic logic [38:0] tm(input int s, input int m, input int h, input int d, input int y);
    return {1'b0, 7'(s), 7'(m), 6'(h), 10'(d), 8'(y)};
  endfunction

  function automatic int fld(input int lo, input int n);
    int r = 0;
    for (int k = 0; k < n; k++) begin
      if (dv[lo+k]) r += 1 << k;
      dv[lo+k] = 1'b0;
    end
    return r;
  endfunction

  // Turns measured high widths back into a time; top bit flags a malformed frame.
  function automatic logic [38:0] decode();
    logic bad;
    int s, m, h, d, y;
    bad = 1'b0;
    dv = '0;
    for (int i = 0; i < 100; i++)
      if (i == 0 || i % 10 == 9) bad |= (w[i] != 80);
      else if (w[i] == 50) dv[i] = 1'b1;
      else if (w[i] != 20) bad = 1'b1;
    s = fld(1, 4) + 10 * fld(6, 3);
    m = fld(10, 4) + 10 * fld(15, 3);
    h = fld(20, 4) + 10 * fld(25, 2);
    d = fld(30, 4) + 10 * fld(35, 4) + 100 * fld(40, 2);
    y = fld(50, 4) + 10 * fld(55, 4);
    bad |= (dv != '0);
    return {bad, 7'(s), 7'(m), 6'(h), 10'(d), 8'(y)};
  endfunction

  // Starts on the first cycle of a frame and ends on the first cycle of the next one.
  task automatic capture();
    for (int b = 0; b < 100; b++) begin
      w[b] = 0;
      for (int c = 0; c < 100; c++) begin
        if (irig_b) w[b]++;
        @(negedge sys_clk);
        load = 1'b0;
      end
    end
    got = decode();
  endtask

  task automatic do_load(input int s, input int m, input int h, input int d, input int y);
    second_in = 7'(s); minute_in = 7'(m); hour_in = 6'(h); day_in = 10'(d); year_in = 8'(y);
    load = 1'b1;
    @(negedge sys_clk);
    load = 1'b0;
  endtask

  task automatic wait_fs(input int lim);
    int n = 0;
    while (!frame_start && n < lim) begin
      @(negedge sys_clk);
      n++;
    end
    vectors++;
    if (frame_start !== 1'b1) begin
      miscompares++;
      $display("FAIL wait_fs: frame_start not seen within %0d cycles", lim);
    end
  endtask

  task automatic test_reset();
    repeat (3) @(negedge sys_clk);
    vectors++;
    if ({irig_b, frame_start, bit_idx, load_err, pending} !== 11'd0) begin
      miscompares++;
      $display("FAIL reset_outputs: got %b exp 0", {irig_b, frame_start, bit_idx, load_err, pending});
    end
    sys_rst_n = 1'b1;
    @(negedge sys_clk);
  endtask

  task automatic test_first_frame();
    int fw[10] = '{80, 50, 20, 20, 50, 20, 50, 20, 50, 80};
    do_load(59, 59, 23, 365, 23);
    vectors++;
    if ({pending, load_err} !== 2'b10) begin
      miscompares++;
      $display("FAIL load_valid: pending/load_err got %b exp 10", {pending, load_err});
    end
    enable = 1'b1;
    @(negedge sys_clk);
    vectors++;
    if ({frame_start, irig_b, bit_idx} !== 9'b110000000) begin
      miscompares++;
      $display("FAIL enable_start: fs/irig/bit got %b exp 110000000", {frame_start, irig_b, bit_idx});
    end
    capture();
    for (int i = 0; i < 10; i++) begin
      vectors++;
      if (w[i] !== fw[i]) begin
        miscompares++;
        $display("FAIL frame1_width bit %0d: got %0d exp %0d", i, w[i], fw[i]);
      end
    end
    vectors++;
    if (got !== tm(59, 59, 23, 365, 23)) begin
      miscompares++;
      $display("FAIL frame1_time: got %h exp %h", got, tm(59, 59, 23, 365, 23));
    end
  endtask

  task automatic test_rollover();
    vectors++;
    if (frame_start !== 1'b1) begin
      miscompares++;
      $display("FAIL gapless: frame_start got %b exp 1", frame_start);
    end
    capture();
    vectors++;
    if (got !== tm(0, 0, 0, 1, 24)) begin
      miscompares++;
      $display("FAIL frame2_time: got %h exp %h", got, tm(0, 0, 0, 1, 24));
    end
    capture();
    vectors++;
    if (got !== tm(1, 0, 0, 1, 24)) begin
      miscompares++;
      $display("FAIL frame3_time: got %h exp %h", got, tm(1, 0, 0, 1, 24));
    end
  endtask

  task automatic test_load_err();
    @(negedge sys_clk);
    do_load(0, 0, 0, 366, 23);
    vectors++;
    if ({load_err, pending} !== 2'b10) begin
      miscompares++;
      $display("FAIL err_day366_y23: load_err/pending got %b exp 10", {load_err, pending});
    end
    do_load(0, 0, 0, 0, 24);
    vectors++;
    if ({load_err, pending} !== 2'b10) begin
      miscompares++;
      $display("FAIL err_day0: load_err/pending got %b exp 10", {load_err, pending});
    end
    do_load(56, 34, 12, 366, 24);
    vectors++;
    if ({load_err, pending} !== 2'b01) begin
      miscompares++;
      $display("FAIL ok_day366_y24: load_err/pending got %b exp 01", {load_err, pending});
    end
    wait_fs(11000);
    vectors++;
    if (pending !== 1'b0) begin
      miscompares++;
      $display("FAIL pending_clear: got %b exp 0", pending);
    end
  endtask

  task automatic test_load_at_fs();
    second_in = 7'd3; minute_in = 7'd2; hour_in = 6'd1; day_in = 10'd100; year_in = 8'd50;
    load = 1'b1;
    capture();
    vectors++;
    if (got !== tm(56, 34, 12, 366, 24)) begin
      miscompares++;
      $display("FAIL fs_load_old: got %h exp %h", got, tm(56, 34, 12, 366, 24));
    end
    capture();
    vectors++;
    if (got !== tm(3, 2, 1, 100, 50)) begin
      miscompares++;
      $display("FAIL fs_load_new: got %h exp %h", got, tm(3, 2, 1, 100, 50));
    end
  endtask

  task automatic test_disable();
    int n = 0;
    while (bit_idx != 7'd37 && n < 5000) begin
      @(negedge sys_clk);
      n++;
    end
    repeat (10) @(negedge sys_clk);
    vectors++;
    if ({bit_idx, irig_b} !== {7'd37, 1'b1}) begin
      miscompares++;
      $display("FAIL mid_bit37: bit/irig got %0d/%b exp 37/1", bit_idx, irig_b);
    end
    enable = 1'b0;
    @(negedge sys_clk);
    vectors++;
    if ({irig_b, bit_idx} !== 8'd0) begin
      miscompares++;
      $display("FAIL disable: irig/bit got %b/%0d exp 0/0", irig_b, bit_idx);
    end
    repeat (5) @(negedge sys_clk);
    enable = 1'b1;
    @(negedge sys_clk);
    vectors++;
    if ({frame_start, irig_b, bit_idx} !== 9'b110000000) begin
      miscompares++;
      $display("FAIL reenable_start: fs/irig/bit got %b exp 110000000", {frame_start, irig_b, bit_idx});
    end
    capture();
    vectors++;
    if (got !== tm(5, 2, 1, 100, 50)) begin
      miscompares++;
      $display("FAIL reenable_time: got %h exp %h", got, tm(5, 2, 1, 100, 50));
    end
  endtask

  task automatic test_reset_mid();
    do_load(10, 10, 10, 10, 10);
    repeat (5) @(negedge sys_clk);
    vectors++;
    if ({irig_b, pending} !== 2'b11) begin
      miscompares++;
      $display("FAIL pre_reset: irig/pending got %b exp 11", {irig_b, pending});
    end
    @(posedge sys_clk);
    #2 sys_rst_n = 1'b0;
    #1;
    vectors++;
    if ({irig_b, frame_start, bit_idx, load_err, pending} !== 11'd0) begin
      miscompares++;
      $display("FAIL async_reset: got %b exp 0", {irig_b, frame_start, bit_idx, load_err, pending});
    end
  endtask

  initial begin
    test_reset();
    test_first_frame();
    test_rollover();
    test_load_err();
    test_load_at_fs();
    test_disable();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
